dadda_mul_arbiter: RTL and testbench
====================================

// Module: dadda_mul_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8x8 pipelined Dadda multiplier between NREQ requesters.
//  - Drives the multiplier operands and tags each issued op with its requester ID through a
//    delay line matched to the multiplier latency.
//  - Buffers products in a result FIFO with a valid/ready output.
//  - Credit-gates issue so a product is never dropped. Sits between client ports and the multiplier.
// PARAMETERS
//  NREQ         4   number of requesters (2..8)
//  MUL_LATENCY  5   clk edges from operands sampled by multiplier to product valid on mul_y
//  RES_DEPTH    8   result FIFO entries, power of 2, must be >= MUL_LATENCY
//  IDW          2   requester ID width, = clog2(NREQ)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  clr        in   1          synchronous flush of in-flight tags and result FIFO
//  req_valid  in   NREQ       per-requester request valid
//  req_a      in   NREQ*8     packed multiplicands, requester i at [8i+7:8i]
//  req_b      in   NREQ*8     packed multipliers, same packing
//  req_ready  out  NREQ       one-hot grant; accept = req_valid[i] & req_ready[i]
//  mul_a      out  8          operand A to multiplier (combinational mux of granted req)
//  mul_b      out  8          operand B to multiplier
//  mul_y      in   16         product from multiplier
//  res_valid  out  1          result FIFO non-empty
//  res_ready  in   1          consumer accepts head entry
//  res_y      out  16         head product
//  res_id     out  IDW        requester ID of head product
//  busy       out  1          ops in flight or results buffered
// BEHAVIOUR
//  Reset values: tags, FIFO pointers and credit count all 0; RR pointer = 0.
//    Outputs: req_ready=0, res_valid=0, busy=0, mul_a=mul_b=0.
//  Reset mid-operation: all in-flight tags are discarded. The multiplier itself needs no reset,
//    because stale products are ignored when their tag valid is 0.
//  Arbitration (combinational each cycle):
//    - Scan from RR pointer upward, wrapping; grant the first i with req_valid[i].
//    - Grant only when credit < RES_DEPTH and clr=0. At most one req_ready bit is high.
//    - req_ready never depends on res_ready in the same cycle.
//    - On accept, RR pointer <= (granted+1) mod NREQ. With no accept, the pointer holds.
//  Operands: mul_a/mul_b = req_a/req_b of the granted i on accept, else 8'h00 (bubble).
//  Tag line: MUL_LATENCY-stage shift register of {valid, id}, shifted every cycle.
//    - Stage 0 loads {accept, granted id}. The last stage aligns with mul_y for the op
//      accepted MUL_LATENCY edges earlier.
//  FIFO push: when tag_last.valid, {mul_y, tag_last.id} is written at the next edge.
//  FIFO pop: res_valid & res_ready.
//    - Simultaneous push and pop is legal; occupancy is unchanged.
//    - Pop on empty is ignored; res_* hold the last value.
//  Credit: credit = in-flight + FIFO occupancy, 0..RES_DEPTH. +1 on accept, -1 on pop;
//    both in one cycle -> unchanged. A pop frees credit one cycle later (no same-cycle bypass).
//    Overflow is impossible by construction; credit == RES_DEPTH blocks all grants.
//  Latency: accept in cycle T -> res_valid high in cycle T+MUL_LATENCY+1 if the FIFO was empty.
//  Throughput: 1 op/cycle sustained while res_ready=1.
//  Ordering: results leave in issue order across all requesters.
//  clr: zeroes tag valids, FIFO pointers and credit at the next edge; no grant that cycle.
//    RR pointer is preserved.
//  busy = (credit != 0).
// STRUCTURE
//  - Header dadda_arb_defs.vh: default NREQ/MUL_LATENCY/RES_DEPTH, PP_W=8, PROD_W=16.
//  - Sub-module dadda_res_fifo: sync FIFO (width PROD_W+IDW, depth RES_DEPTH, clr, async rst).
//  - RR grant logic and tag line stay inline.
//  - Multiplier is instantiated beside this block at top level: mul_a/mul_b -> A/B, y -> mul_y.
//    Its active-low rst is tied inactive.
// TESTING (bench pairs block with the real pipelined multiplier)
//  1. Single op: req_valid=4'b0001, a=8'd13, b=8'd11 in cycle 0 -> cycle 6:
//     res_valid=1, res_y=16'd143, res_id=0.
//  2. All 4 requesting every cycle, res_ready=1 -> grants 0,1,2,3,0,... one per cycle.
//     Each res_y equals a*b of its operands, incl. 255*255 = 16'hFE01.
//  3. res_ready=0 with 2 requesters streaming -> exactly 8 accepts, then req_ready=0.
//     Raising res_ready resumes issue one cycle after the first pop; no product lost.
//  4. Simultaneous: credit=7 with accept and pop in the same cycle -> credit stays 7,
//     FIFO content ordered.
//  5. rst pulsed with 3 ops in flight -> outputs 0 immediately.
//     Next op 0*200 -> res_y=0, res_id correct; no stale results appear.
//  6. clr with 5 buffered + 2 in flight -> res_valid=0 next cycle, busy=0.
//     Subsequent op 7*9 -> 16'd63.

Source files
------------

// File: rtl/dadda_mul_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dadda_mul_arbiter_pkg
// Brief  : Shared widths and defaults for the Dadda multiplier arbiter.
// Rev    : 1.0
// ============================================================================
package dadda_mul_arbiter_pkg;

  localparam int c_PP_W             = 8;
  localparam int c_PROD_W           = 16;
  localparam int c_NREQ_DEF         = 4;
  localparam int c_MUL_LATENCY_DEF  = 5;
  localparam int c_RES_DEPTH_DEF    = 8;

  typedef logic [c_PP_W-1:0]   operand_t;
  typedef logic [c_PROD_W-1:0] product_t;

endpackage
`default_nettype wire

// File: rtl/dadda_res_fifo.sv
`default_nettype none
// ============================================================================
// Module : dadda_res_fifo
// Brief  : Synchronous result FIFO with flush; the head holds the last popped entry when empty.
// Rev    : 1.0
// ============================================================================
module dadda_res_fifo
  import dadda_mul_arbiter_pkg::*;
#(
  parameter int W     = c_PROD_W + 2,
  parameter int DEPTH = c_RES_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int c_AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic [c_AW:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_push = push && !full && !clr;
  assign w_do_pop  = pop && !empty && !clr;

  // When empty, present the slot just behind the read pointer (last popped entry).
  assign w_rd_idx  = empty ? (r_rd_ptr - (c_AW+1)'(1)) : r_rd_ptr;
  assign pop_data  = r_mem[w_rd_idx[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dadda_mul_arbiter
// Brief  : Round-robin, credit-gated issue of NREQ requesters onto one pipelined
//          8x8 multiplier, with ID tag line and result FIFO.
// Rev    : 1.0
// ============================================================================
module dadda_mul_arbiter
  import dadda_mul_arbiter_pkg::*;
#(
  parameter int NREQ        = c_NREQ_DEF,
  parameter int MUL_LATENCY = c_MUL_LATENCY_DEF,
  parameter int RES_DEPTH   = c_RES_DEPTH_DEF,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*c_PP_W-1:0] req_a,
  input  logic [NREQ*c_PP_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [c_PP_W-1:0]      mul_a,
  output logic [c_PP_W-1:0]      mul_b,
  input  logic [c_PROD_W-1:0]    mul_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [c_PROD_W-1:0]    res_y,
  output logic [IDW-1:0]         res_id,
  output logic                   busy
);

  localparam int c_CW = $clog2(RES_DEPTH + 1);
  localparam int c_FW = c_PROD_W + IDW;

  operand_t          w_a [NREQ];
  operand_t          w_b [NREQ];
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    w_hi_id;
  logic [IDW-1:0]    w_lo_id;
  logic [IDW-1:0]    w_gnt_id;
  logic              w_hi_found;
  logic              w_lo_found;
  logic              w_grant_en;
  logic              w_accept;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [c_FW-1:0]   w_fifo_out;
  logic [c_CW-1:0]   r_credit;
  logic [MUL_LATENCY-1:0] r_tag_v;
  logic [IDW-1:0]    r_tag_id [MUL_LATENCY];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_a[gi] = req_a[gi*c_PP_W +: c_PP_W];
      assign w_b[gi] = req_b[gi*c_PP_W +: c_PP_W];
    end
  endgenerate

  // Two-pass scan: first valid at or above the pointer, else first valid from 0.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_found = 1'b0;
    w_lo_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_hi_found && req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_hi_found = 1'b1;
        w_hi_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_lo_found && req_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_id    = IDW'(i);
      end
    end
  end

  assign w_gnt_id   = w_hi_found ? w_hi_id : w_lo_id;
  assign w_grant_en = !rst && !clr && (r_credit < c_CW'(RES_DEPTH));
  assign w_accept   = w_grant_en && w_lo_found;
  assign req_ready  = w_accept ? (NREQ'(1) << w_gnt_id) : '0;
  assign mul_a      = w_accept ? w_a[w_gnt_id] : '0;
  assign mul_b      = w_accept ? w_b[w_gnt_id] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
    end
  end

  // Tag line: last stage lines up with the multiplier product of the same op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= w_accept;
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1] && !clr;
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_pop = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= '0;
    end else if (clr) begin
      r_credit <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + c_CW'(1);
        2'b01:   r_credit <= r_credit - c_CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  dadda_res_fifo #(
    .W     (c_FW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (r_tag_v[MUL_LATENCY-1]),
    .push_data ({mul_y, r_tag_id[MUL_LATENCY-1]}),
    .pop       (w_pop),
    .pop_data  (w_fifo_out),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  assign res_valid = !w_fifo_empty;
  assign res_y     = w_fifo_out[IDW +: c_PROD_W];
  assign res_id    = w_fifo_out[IDW-1:0];
  assign busy      = (r_credit != '0);

  // Credit gating keeps the FIFO from ever being pushed while full.
  logic w_unused;
  assign w_unused = w_fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dadda_mul_arbiter
// Brief  : Scoreboard bench pairing the arbiter with a behavioural pipelined multiplier.
// Rev    : 1.0
// ============================================================================
module tb_dadda_mul_arbiter;

  localparam int NREQ        = 4;
  localparam int MUL_LATENCY = 5;
  localparam int RES_DEPTH   = 8;
  localparam int IDW         = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_y;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [15:0]       res_y;
  logic [IDW-1:0]    res_id;
  logic              busy;

  logic [7:0] a_arr [NREQ];
  logic [7:0] b_arr [NREQ];
  logic [15:0] mpipe [MUL_LATENCY];

  typedef struct {
    int          rdy;
    logic [1:0]  id;
    logic [15:0] y;
  } exp_t;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   dut_acc = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  dadda_mul_arbiter #(
    .NREQ        (NREQ),
    .MUL_LATENCY (MUL_LATENCY),
    .RES_DEPTH   (RES_DEPTH),
    .IDW         (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_y     (mul_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*8 +: 8] = a_arr[i];
      req_b[i*8 +: 8] = b_arr[i];
    end
  end

  // Pipelined multiplier stand-in, never reset.
  always @(posedge clk) begin
    mpipe[0] <= 16'(mul_a) * 16'(mul_b);
    for (int i = 1; i < MUL_LATENCY; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_y = mpipe[MUL_LATENCY-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Reference model: round-robin over valid requesters, credit = ops not yet popped.
  initial forever begin
    logic            found;
    int              gid;
    logic [NREQ-1:0] eg;
    exp_t            e;
    @(negedge clk);
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_operands", {16'h0, mul_a, mul_b}, 0);
      sb_q.delete();
      m_ptr = 0;
    end else begin
      found = 1'b0;
      gid   = 0;
      if (!clr && sb_q.size() < RES_DEPTH)
        for (int k = 0; k < NREQ; k++)
          if (!found && req_valid[(m_ptr + k) % NREQ]) begin
            found = 1'b1;
            gid   = (m_ptr + k) % NREQ;
          end
      eg = '0;
      if (found) eg[gid] = 1'b1;
      chk("grant", 32'(req_ready), 32'(eg));
      chk("operands", {16'h0, mul_a, mul_b}, found ? {16'h0, a_arr[gid], b_arr[gid]} : 32'h0);
      chk("res_valid", 32'(res_valid), 32'(sb_q.size() > 0 && sb_q[0].rdy <= cyc));
      chk("busy", 32'(busy), 32'(sb_q.size() != 0));
      if (|(req_valid & req_ready)) dut_acc++;
      if (found) begin
        e.rdy = cyc + MUL_LATENCY + 1;
        e.id  = 2'(gid);
        e.y   = 16'(a_arr[gid]) * 16'(b_arr[gid]);
        sb_q.push_back(e);
        m_ptr = (gid + 1) % NREQ;
      end
      if (clr) sb_q.delete();
    end
  end

  // Monitor: compares every accepted result against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && res_valid && res_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("res_y", 32'(res_y), 32'(e.y));
        chk("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ops(input int rnd);
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = rnd ? 8'($urandom) : 8'h00;
      b_arr[i] = rnd ? 8'($urandom) : 8'h00;
    end
  endtask

  task automatic wait_result(input string name, input int c0, input int lat,
                             input logic [15:0] y, input logic [1:0] id);
    int seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #3;
      if (res_valid) seen = 1;
    end
    chk({name, "_latency"}, 32'(cyc - c0), 32'(lat));
    chk({name, "_y"}, 32'(res_y), 32'(y));
    chk({name, "_id"}, 32'(res_id), 32'(id));
  endtask

  initial begin
    int c0;
    int acc0;
    set_ops(0);
    step(3);
    rst = 1'b0;
    step(2);

    // Single op from requester 0
    res_ready = 1'b1;
    a_arr[0] = 8'd13; b_arr[0] = 8'd11; req_valid = 4'b0001;
    c0 = cyc;
    step(1);
    req_valid = '0;
    wait_result("t1", c0, MUL_LATENCY + 1, 16'd143, 2'd0);
    step(4);

    // All requesters streaming, with periodic 255*255
    req_valid = 4'hF;
    for (int n = 0; n < 48; n++) begin
      set_ops(1);
      if (n % 8 == 3) for (int i = 0; i < NREQ; i++) begin a_arr[i] = 8'hFF; b_arr[i] = 8'hFF; end
      step(1);
    end
    req_valid = '0;
    step(12);

    // Back-pressure: only RES_DEPTH ops may be issued
    res_ready = 1'b0;
    req_valid = 4'b0011;
    set_ops(1);
    acc0 = dut_acc;
    step(20);
    @(negedge clk);
    #3;
    chk("t3_accepts", 32'(dut_acc - acc0), 32'(RES_DEPTH));
    chk("t3_blocked", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin set_ops(1); step(1); end
    req_valid = '0;
    step(15);

    // Asynchronous reset with ops in flight
    req_valid = 4'b0111;
    set_ops(1);
    step(3);
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req_ready", 32'(req_ready), 0);
    chk("t5_res_valid", 32'(res_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);
    a_arr[2] = 8'd0; b_arr[2] = 8'd200; req_valid = 4'b0100;
    c0 = cyc;
    step(1);
    req_valid = '0;
    wait_result("t5", c0, MUL_LATENCY + 1, 16'd0, 2'd2);
    step(10);

    // Flush with 5 buffered and 2 in flight
    res_ready = 1'b0;
    req_valid = 4'b0001;
    for (int n = 0; n < 7; n++) begin set_ops(1); step(1); end
    req_valid = '0;
    step(3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    @(negedge clk);
    #3;
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    a_arr[0] = 8'd7; b_arr[0] = 8'd9; req_valid = 4'b0001;
    c0 = cyc;
    step(1);
    req_valid = '0;
    wait_result("t6", c0, MUL_LATENCY + 1, 16'd63, 2'd0);
    step(5);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_ops(1);
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 40) == 0);
      if (clr) res_ready = 1'b0;
      step(1);
    end
    req_valid = '0;
    clr       = 1'b0;
    res_ready = 1'b1;
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) step(1);
    step(2);
    chk("drain_empty", 32'(sb_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
